frame_deserializer: RTL

//  Receive end of the FSK link. Recovers framed serial words from the demodulated line
//  (fsk_demodulator output) and presents them as parallel data with a valid/ack handshake.

---
 rtl/frame_deserializer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_deserializer.sv
// Framed serial receiver: idle 1, start 0, DATA_W bits MSB first, [even parity], stop 1.
// Define PARITY_CHECK_EN to expect and check an even-parity bit before the stop bit.
module frame_deserializer #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned BIT_CYCLES  = 208,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              signal_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    DONE,
    BREAK
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   line, line_q;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_W-1:0]      shreg, shreg_n;
  logic [DATA_W-1:0]      rx_data_n;
  logic                   rx_valid_n, frame_err_n, overrun_n;

  assign line    = sync[SYNC_STAGES-1];
  assign rx_busy = (state != IDLE);

`ifdef PARITY_CHECK_EN
  logic par, par_n, parity_err_n;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CW'(1);
    idx_n       = idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef PARITY_CHECK_EN
    par_n        = par;
    parity_err_n = 1'b0;
`endif
    // A load in DONE overrides this ack-driven clear.
    if (rx_ack && rx_valid) rx_valid_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (line_q && !line) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          idx_n = '0;
`ifdef PARITY_CHECK_EN
          par_n = 1'b0;
`endif
          state_n = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = (shreg << 1) | DATA_W'(line);
`ifdef PARITY_CHECK_EN
          par_n = par ^ line;
`endif
          if (idx == IDX_LAST) begin
`ifdef PARITY_CHECK_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          par_n   = par ^ line;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (line) begin
            state_n = DONE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
`ifdef PARITY_CHECK_EN
        if (par) begin
          parity_err_n = 1'b1;
        end else
`endif
        if (!rx_valid || rx_ack) begin
          rx_data_n  = shreg;
          rx_valid_n = 1'b1;
        end else begin
          overrun_n = 1'b1;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (line) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '1;
      line_q    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], signal_in};
      line_q    <= line;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
`ifdef PARITY_CHECK_EN
      par        <= par_n;
      parity_err <= parity_err_n;
`endif
    end
  end

endmodule
